// File: rtl/morse_encoder.sv
// morse_encoder: 4-deep host FIFO feeding a Morse keyer on active-low line b.
// One unit is TIMER_FINAL_VALUE+1 clocks; b idles high.
module morse_encoder #(
  parameter int TIMER_FINAL_VALUE = 5,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [8:0] din,
  output logic       b,
  output logic       full,
  output logic       empty,
  output logic       busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TIMER_FINAL_VALUE > 0) ?
                      $clog2(TIMER_FINAL_VALUE + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    ELEM_GAP,
    LETTER_GAP,
    WORD_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    units_q, units_d;
  logic [4:0]    sr_q, sr_d;
  logic [2:0]    ecnt_q, ecnt_d;
  logic          b_q, b_d;
  logic          busy_q, busy_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  logic       tick;
  logic       done;
  logic       push;
  logic       pop;
  logic       load;
  logic [1:0] need_m1;
  logic [8:0] head;
  logic [2:0] head_len;

  always_comb begin
    tick     = (timer_q == TW'(TIMER_FINAL_VALUE));
    head     = mem_q[rp_q];
    head_len = (head[7:5] > 3'd5) ? 3'd5 : head[7:5];
    push     = wr & ~full_q & ~reset;

    unique case (state_q)
      MARK:       need_m1 = sr_q[4] ? 2'd2 : 2'd0;
      LETTER_GAP: need_m1 = 2'd2;
      WORD_GAP:   need_m1 = 2'd3;
      default:    need_m1 = 2'd0;
    endcase
    done = tick && (units_q == need_m1) && (state_q != IDLE);

    state_d = state_q;
    sr_d    = sr_q;
    ecnt_d  = ecnt_q;
    load    = 1'b0;

    unique case (state_q)
      IDLE: load = (cnt_q != '0);
      MARK: begin
        if (done) begin
          if (ecnt_q != 3'd0) begin
            state_d = ELEM_GAP;
            sr_d    = {sr_q[3:0], 1'b0};
            ecnt_d  = ecnt_q - 3'd1;
          end else begin
            state_d = LETTER_GAP;
          end
        end
      end
      ELEM_GAP: begin
        if (done) state_d = MARK;
      end
      LETTER_GAP, WORD_GAP: begin
        if (done) begin
          load    = (cnt_q != '0);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A popped len=0 letter is consumed but leaves the keyer idle.
    if (load) begin
      if (head[8]) begin
        state_d = WORD_GAP;
      end else if (head_len == 3'd0) begin
        state_d = IDLE;
      end else begin
        state_d = MARK;
        sr_d    = head[4:0];
        ecnt_d  = head_len - 3'd1;
      end
    end
    pop = load;

    if (load || done || state_q == IDLE) begin
      timer_d = '0;
      units_d = 2'd0;
    end else begin
      timer_d = tick ? '0 : timer_q + TW'(1);
      units_d = units_q + {1'b0, tick};
    end

    wp_d    = wp_q + PW'(push);
    rp_d    = rp_q + PW'(pop);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    full_d  = (cnt_d == CW'(FIFO_DEPTH));
    empty_d = (cnt_d == '0);
    b_d     = (state_d != MARK);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      units_q <= 2'd0;
      sr_q    <= 5'd0;
      ecnt_q  <= 3'd0;
      b_q     <= 1'b1;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      units_q <= units_d;
      sr_q    <= sr_d;
      ecnt_q  <= ecnt_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end

  assign b     = b_q;
  assign busy  = busy_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: waveform model built from unit timing rules,
// plus directed letters with hand-computed run lengths.
module tb_morse_encoder;

  localparam int TFV   = 5;
  localparam int U     = TFV + 1;
  localparam int DEPTH = 4;

  localparam logic [8:0] L_E  = 9'b0_001_00000;
  localparam logic [8:0] L_T  = 9'b0_001_10000;
  localparam logic [8:0] L_A  = 9'b0_010_01000;
  localparam logic [8:0] L_SP = 9'b1_000_00000;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       wr    = 1'b0;
  logic [8:0] din   = '0;
  logic       b, full, empty, busy;

  int errors = 0;
  int checks = 0;

  morse_encoder #(
    .TIMER_FINAL_VALUE(TFV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr(wr),
    .din(din),
    .b(b),
    .full(full),
    .empty(empty),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Model: queue of pending entries and queue of future b levels.
  logic [8:0] m_fifo[$];
  bit         m_bits[$];
  bit         m_b = 1'b1;
  bit         m_busy = 1'b0;
  bit         m_valid = 1'b0;
  bit         was_full;

  int marks[$];
  int gaps[$];
  int lo_n = 0;
  int hi_n = 0;
  int busy_n = 0;
  bit seen = 1'b0;

  function automatic void expand(input logic [8:0] e);
    int n;
    if (e[8]) begin
      repeat (4 * U) m_bits.push_back(1'b1);
      return;
    end
    n = (e[7:5] > 3'd5) ? 5 : int'(e[7:5]);
    for (int i = 0; i < n; i++) begin
      repeat ((e[4-i] ? 3 : 1) * U) m_bits.push_back(1'b0);
      repeat ((i == n - 1 ? 3 : 1) * U) m_bits.push_back(1'b1);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_fifo.delete();
      m_bits.delete();
      m_valid = 1'b1;
    end else begin
      was_full = (m_fifo.size() == DEPTH);
      if (m_bits.size() == 0 && m_fifo.size() > 0)
        expand(m_fifo.pop_front());
      if (wr && !was_full) m_fifo.push_back(din);
    end
    if (m_bits.size() > 0) begin
      m_b    = m_bits.pop_front();
      m_busy = 1'b1;
    end else begin
      m_b    = 1'b1;
      m_busy = 1'b0;
    end
    #1;
    if (m_valid) begin
      check("b", b, m_b);
      check("busy", busy, m_busy);
      check("full", full, m_fifo.size() == DEPTH);
      check("empty", empty, m_fifo.size() == 0);
      if (b == 1'b0) begin
        if (seen && hi_n > 0) gaps.push_back(hi_n);
        hi_n = 0;
        lo_n++;
        seen = 1'b1;
      end else begin
        if (lo_n > 0) marks.push_back(lo_n);
        lo_n = 0;
        hi_n++;
      end
      if (busy) busy_n++;
    end
  end

  task automatic clr_rec();
    marks.delete();
    gaps.delete();
    lo_n   = 0;
    hi_n   = 0;
    busy_n = 0;
    seen   = 1'b0;
  endtask

  task automatic put(input logic [8:0] d);
    @(negedge clk);
    wr  = 1'b1;
    din = d;
  endtask

  task automatic rel();
    @(negedge clk);
    wr  = 1'b0;
    din = '0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(busy == 1'b0 && empty == 1'b1) && n < maxc);
    if (n >= maxc) check({name, "_timeout"}, 1, 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_b", b, 1);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_busy", busy, 0);

    // E: 6 low, 24 busy, empty back one cycle after the write
    clr_rec();
    put(L_E);
    @(posedge clk);
    #2;
    check("e_empty_w", empty, 0);
    rel();
    @(posedge clk);
    #2;
    check("e_empty_pop", empty, 1);
    check("e_b_low", b, 0);
    check("e_busy", busy, 1);
    wait_idle("e", 200);
    check("e_nmarks", marks.size(), 1);
    check("e_mark0", qat(marks, 0), 6);
    check("e_busy_n", busy_n, 24);

    // A: low 6, high 6, low 18, high 18
    clr_rec();
    put(L_A);
    rel();
    wait_idle("a", 300);
    check("a_nmarks", marks.size(), 2);
    check("a_mark0", qat(marks, 0), 6);
    check("a_gap0", qat(gaps, 0), 6);
    check("a_mark1", qat(marks, 1), 18);
    check("a_busy_n", busy_n, 48);

    // E, space, E: 42 high cycles between marks
    clr_rec();
    put(L_E);
    put(L_SP);
    put(L_E);
    rel();
    wait_idle("ese", 400);
    check("ese_nmarks", marks.size(), 2);
    check("ese_gap", qat(gaps, 0), 42);
    check("ese_busy_n", busy_n, 72);

    // six consecutive writes: fifth fills, sixth dropped
    clr_rec();
    for (int i = 0; i < 5; i++) put(L_E);
    @(posedge clk);
    #2;
    check("fill_full", full, 1);
    put(L_E);
    rel();
    wait_idle("fill", 2000);
    check("fill_nmarks", marks.size(), 5);

    // len=0 discarded silently
    clr_rec();
    put(9'b0_000_10101);
    rel();
    repeat (60) @(posedge clk);
    #2;
    check("len0_nmarks", marks.size(), 0);
    check("len0_busy_n", busy_n, 0);

    // len=7 clamps to 5 dashes
    clr_rec();
    put(9'b0_111_11111);
    rel();
    wait_idle("len7", 1000);
    check("len7_nmarks", marks.size(), 5);
    for (int i = 0; i < 5; i++) check("len7_dash", qat(marks, i), 18);
    check("len7_ngaps", gaps.size(), 4);
    check("len7_gap", qat(gaps, 3), 6);

    // reset mid-dash with two queued entries
    clr_rec();
    put(L_T);
    put(L_E);
    put(L_E);
    rel();
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("mid_dash", b, 0);
    reset = 1'b1;
    wr    = 1'b1;
    din   = L_E;
    @(negedge clk);
    reset = 1'b0;
    wr    = 1'b0;
    din   = '0;
    check("rst2_b", b, 1);
    check("rst2_empty", empty, 1);
    check("rst2_busy", busy, 0);
    check("rst2_full", full, 0);
    clr_rec();
    repeat (150) @(posedge clk);
    #2;
    check("rst2_nmarks", marks.size(), 0);
    check("rst2_busy_n", busy_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/morse_encoder.md
# morse_encoder

Morse transmitter: the counterpart of the morse decoder. It accepts letter codes from a host-side write port into a 4-entry FIFO and keys them onto the active-low line `b` with standard unit timing: dot 1, dash 3, element gap 1, letter gap 3, word gap 7. The unit length uses the decoder's timer convention, so `b` can drive the decoder's `b` input directly for loopback testing.

## Interface
- `TIMER_FINAL_VALUE`, default 5: the unit-timer terminal count. One unit is TIMER_FINAL_VALUE+1 clk cycles.
- `FIFO_DEPTH`, default 4: number of entries. Must be a power of 2, at least 2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr`  in  1  write strobe. Sampled each edge.
- `din`  in  9  entry, packed as {space, len[2:0], pattern[4:0]}.
  - `pattern[4]` is the first element sent.
  - Pattern bit 1 is a dash; bit 0 is a dot.
- `b`  out  1  keyed line, registered. 0 means key down (mark); 1 means idle or gap.
- `full`  out  1  FIFO holds FIFO_DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- Write port:
  - `wr & ~full` at an edge stores `din` and increments the count.
  - `wr & full` is ignored. Nothing is stored or overwritten, even if the FSM pops on the same edge.
  - The FIFO pops only from IDLE, or at the end of LETTER_GAP or WORD_GAP.
- Entry decode at pop:
  - `space`=1: a word-space entry. `len` and `pattern` are ignored.
  - `space`=0, `len`=0: discarded. It produces no output and no gap, and the FSM stays or returns to IDLE.
  - `len` 6 or 7: clamped to 5.
- Element sequencing: the pattern is loaded into a shift register and shifted left once per element. An element counter runs from len−1 down to 0.
- Unit timer:
  - Cleared to 0 on every state entry.
  - Counts 0..TIMER_FINAL_VALUE.
  - Asserts a one-cycle `tick` at the terminal count.
  - A duration of N units ends on the N-th tick.
- FSM states:
  - IDLE (b=1): if FIFO is non-empty, pop and go to MARK (letter entry) or WORD_GAP (space entry).
  - MARK (b=0): lasts 1 unit for a dot, 3 units for a dash. Then go to ELEM_GAP if elements remain, else LETTER_GAP.
  - ELEM_GAP (b=1): lasts 1 unit, then MARK with the next element.
  - LETTER_GAP (b=1): lasts 3 units. Then pop the next entry directly into MARK or WORD_GAP if available, else go to IDLE.
  - WORD_GAP (b=1): lasts 4 units, making 7 total when it follows a letter gap. Then behaves like the end of LETTER_GAP.
  - A space entry popped from IDLE still lasts exactly 4 units.
- `b` is driven from a register updated on the same edge as the state transition, so `b` is glitch-free.

## Timing
- Reset values: `b`=1, `full`=0, `empty`=1, `busy`=0. The FIFO pointers, count, timer and FSM clear to IDLE.
- `reset` mid-operation: the next edge forces all reset values, aborts the current letter and flushes the FIFO. A `wr` on that edge is discarded.
- Write to output latency: a write at edge E0 into an empty FIFO with the FSM idle is popped at E1. `b`=0 and `busy`=1 are visible after E1.
- `full` and `empty` are registered from the count and reflect the edge they follow.
- A pop and a write on the same edge leave the count unchanged.
- Durations in cycles for the default TIMER_FINAL_VALUE=5 (U = 6 cycles):
  - dot low: 6
  - dash low: 18
  - element gap: 6
  - letter gap: 18
  - word space: 24 additional, giving 42 cycles high between letters.
- `busy` deasserts on the edge where LETTER_GAP or WORD_GAP ends with the FIFO empty.
- Back-to-back letters have no idle cycle between LETTER_GAP and the next MARK.

## Test plan
- Reset, then write 'E' (din=9'b0_001_00000):
  - `b` low for exactly 6 cycles starting one cycle after the write, then high.
  - `busy` high for 24 cycles total.
  - `empty` returns to 1 one cycle after the write.
- Write 'A' (9'b0_010_01000): `b` runs low 6, high 6, low 18, then high 18, then `busy`=0.
- Write 'E', space (9'b1_000_00000), 'E' on consecutive cycles: the two 6-cycle marks are separated by exactly 42 high cycles.
- Write 6 entries on 6 consecutive cycles from idle:
  - `full`=1 after the 5th write.
  - The 6th write is dropped.
  - Exactly 5 letters are keyed, and `empty`=1 only after the 5th pop.
- Write len=0 and len=7 entries:
  - The len=0 entry produces no activity on `b`.
  - The len=7 entry with pattern 11111 keys 5 dashes.
- Assert `reset` for one cycle in the middle of a dash with 2 entries queued:
  - `b`=1, `empty`=1 and `busy`=0 after that edge.
  - No further marks appear.
- Loopback: drive the `b` output into the morse decoder's `b` input with TIMER_FINAL_VALUE matched; the decoder must report the same letters that were written.
